// File: rtl/pc_pkg.sv
// Shared types, constants and helpers for the fetch program-counter unit.
package pc_pkg;

  // Default PC width and sequential increment for the core.
  localparam int unsigned PC_XLEN       = 32;
  localparam int unsigned PC_INST_BYTES = 4;
  localparam int unsigned PC_INST_LSB   = $clog2(PC_INST_BYTES);

  // Fetch FSM: IDLE holds the PC with fetch invalid, RUN fetches.
  typedef enum logic [0:0] {
    PC_IDLE = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_e;

  // Clear the low 'lsb' bits of an address (widths up to 64 bits).
  function automatic logic [63:0] align_pc(input logic [63:0] pc, input int unsigned lsb);
    return pc & ~((64'd1 << lsb) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: the lowest-index valid port wins.
module pc_redir_arb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = PC_XLEN,
  parameter int unsigned NUM_REDIR = 2
) (
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
  output logic                      any_valid_o,
  output logic [XLEN-1:0]           target_o
);

  // Scan from the lowest priority upward so that port 0 overrides everything.
  always_comb begin
    any_valid_o = 1'b0;
    target_o    = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        any_valid_o = 1'b1;
        target_o    = redir_target_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: auto-increment, prioritised redirects, and a
// one-entry pending buffer that holds a redirect seen during a stall or while
// idle until the PC is free to move.
//
// Redirect interface: redir_valid_i[k] is a single-cycle request with no
// ready/backpressure. A request is always consumed in the cycle it is valid:
// it either moves the PC, or (stall or idle) lands in the pending buffer,
// overwriting any older buffered target. Only when running is stopped
// (RUN with start_i=0) is a request dropped, and the buffer is retained.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned   XLEN       = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned   INST_BYTES = PC_INST_BYTES,
  parameter int unsigned   NUM_REDIR  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      stall_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pc_valid_o,
  output logic [XLEN-1:0]           pc_plus_o,
  output logic                      redir_pending_o,
  output logic                      state_o
);

  localparam int unsigned INST_LSB = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 0;
  localparam logic [XLEN-1:0] INC  = XLEN'(INST_BYTES);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  logic            arb_any;
  logic [XLEN-1:0] arb_tgt;
  logic [63:0]     arb_tgt_wide;
  logic [XLEN-1:0] tgt_al;

  pc_redir_arb #(
    .XLEN      (XLEN),
    .NUM_REDIR (NUM_REDIR)
  ) u_arb (
    .redir_valid_i  (redir_valid_i),
    .redir_target_i (redir_target_i),
    .any_valid_o    (arb_any),
    .target_o       (arb_tgt)
  );

  // Targets are forced onto an instruction boundary before they are used or buffered.
  assign arb_tgt_wide = align_pc(64'(arb_tgt), INST_LSB);
  assign tgt_al       = arb_tgt_wide[XLEN-1:0];

  // State, PC and pending buffer; async active-low reset discards everything.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= PC_IDLE;
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next-state and next-PC selection in priority order.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      PC_IDLE: begin
        // First fetch happens at the held PC, so the PC does not move here.
        if (start_i) state_d = PC_RUN;
        if (arb_any) begin
          pend_d     = 1'b1;
          pend_tgt_d = tgt_al;
        end
      end
      PC_RUN: begin
        if (!start_i) begin
          state_d = PC_IDLE;
        end else if (arb_any && !stall_i) begin
          pc_d   = tgt_al;
          pend_d = 1'b0;
        end else if (arb_any) begin
          pend_d     = 1'b1;
          pend_tgt_d = tgt_al;
        end else if (!stall_i && pend_q) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
        end else if (!stall_i) begin
          pc_d = pc_q + INC;
        end
      end
      default: begin
        state_d = PC_IDLE;
      end
    endcase
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = (state_q == PC_RUN);
  assign pc_plus_o       = pc_q + INC;
  assign redir_pending_o = pend_q;
  assign state_o         = state_q;

endmodule
